// File: rtl/cpu_pkg.sv
// Shared CPU register-file parameters, write-back payload type and address helper.
package cpu_pkg;

  localparam int unsigned WORD       = 4;
  localparam int unsigned WIDTH      = 8;
  localparam int unsigned ADDR_WIDTH = 4;
  localparam int unsigned CNT_W      = 2;

  localparam int unsigned DATA_W = WORD * WIDTH;
  localparam int unsigned WA_W   = ADDR_WIDTH * WIDTH;
  localparam int unsigned NREG   = (1 << ADDR_WIDTH) / WORD;
  localparam int unsigned RIDX   = $clog2(NREG);
  localparam int unsigned OFS_W  = $clog2(WORD);

  typedef logic [RIDX-1:0]   reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

  typedef struct packed {
    reg_idx_t rd;
    word_t    data;
  } wb_req_t;

  typedef enum logic {
    RR_A = 1'b0,
    RR_B = 1'b1
  } rr_side_t;

  // Register index to regfile byte address, zero-extended to the write-address width.
  function automatic logic [WA_W-1:0] reg_to_addr(input reg_idx_t r);
    return WA_W'({r, OFS_W'(0)});
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write counters: claim acceptance, decode stall and sticky underflow error.
module regfile_scoreboard
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            claim_valid,
  input  logic [RIDX-1:0] claim_reg,
  output logic            claim_ready,
  input  logic            commit,
  input  logic [RIDX-1:0] commit_reg,
  input  logic [RIDX-1:0] rs1,
  input  logic [RIDX-1:0] rs2,
  input  logic            rs1_used,
  input  logic            rs2_used,
  output logic            stall,
  output logic            sb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [NREG-1:0]  inc_c;
  logic [NREG-1:0]  dec_c;
  logic             claim_acc_c;
  logic             err_d;

  // A commit to a saturated register frees a slot on the same edge, so the claim may proceed.
  always_comb begin
    claim_ready = (cnt_q[claim_reg] != CNT_MAX) || (commit && (commit_reg == claim_reg));
    claim_acc_c = claim_valid && claim_ready;
    stall       = (rs1_used && (cnt_q[rs1] != '0)) || (rs2_used && (cnt_q[rs2] != '0));
  end

  always_comb begin
    err_d = sb_err;
    for (int i = 0; i < NREG; i++) begin
      inc_c[i] = claim_acc_c && (claim_reg == RIDX'(i));
      dec_c[i] = commit && (commit_reg == RIDX'(i));
      cnt_d[i] = cnt_q[i];
      if (inc_c[i] && !dec_c[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec_c[i] && !inc_c[i]) begin
        if (cnt_q[i] == '0) begin
          err_d = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        cnt_q[i] <= '0;
      end
      sb_err <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      sb_err <= err_d;
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Round-robin sharing of the regfile write port between ALU and load write-back,
// with a pending-write scoreboard driving decode stalls.
module regfile_wb_sched
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [RIDX-1:0]   a_reg,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [RIDX-1:0]   b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              claim_valid,
  input  logic [RIDX-1:0]   claim_reg,
  output logic              claim_ready,
  input  logic [RIDX-1:0]   rs1,
  input  logic [RIDX-1:0]   rs2,
  input  logic              rs1_used,
  input  logic              rs2_used,
  output logic              stall,
  output logic              we,
  output logic [WA_W-1:0]   wa,
  output logic [DATA_W-1:0] wd,
  output logic              sb_err
);

  rr_side_t rr_q;
  rr_side_t rr_d;
  wb_req_t  sel_c;
  logic     grant_c;

  // Round-robin pointer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= RR_A;
    end else begin
      rr_q <= rr_d;
    end
  end

  // Pointer only moves after a contended grant.
  always_comb begin
    rr_d = rr_q;
    if (a_valid && b_valid) begin
      rr_d = (rr_q == RR_A) ? RR_B : RR_A;
    end
  end

  // Grant decode and payload select.
  always_comb begin
    a_ready    = a_valid && (!b_valid || (rr_q == RR_A));
    b_ready    = b_valid && (!a_valid || (rr_q == RR_B));
    grant_c    = a_ready || b_ready;
    sel_c.rd   = a_reg;
    sel_c.data = a_data;
    if (b_ready) begin
      sel_c.rd   = b_reg;
      sel_c.data = b_data;
    end
  end

  // Write port registers; address and data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we <= 1'b0;
      wa <= '0;
      wd <= '0;
    end else begin
      we <= grant_c;
      if (grant_c) begin
        wa <= reg_to_addr(sel_c.rd);
        wd <= sel_c.data;
      end
    end
  end

  regfile_scoreboard u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .claim_valid (claim_valid),
    .claim_reg   (claim_reg),
    .claim_ready (claim_ready),
    .commit      (we),
    .commit_reg  (wa[OFS_W +: RIDX]),
    .rs1         (rs1),
    .rs2         (rs2),
    .rs1_used    (rs1_used),
    .rs2_used    (rs2_used),
    .stall       (stall),
    .sb_err      (sb_err)
  );

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched with a behavioural regfile fed by we/wa/wd.
module tb_regfile_wb_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid, claim_valid;
  logic [1:0]  a_reg, b_reg, claim_reg, rs1, rs2;
  logic [31:0] a_data, b_data;
  logic        rs1_used, rs2_used;
  logic        a_ready, b_ready, claim_ready, stall, we, sb_err;
  logic [31:0] wa, wd;

  logic [31:0] mem [4];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (we) mem[wa[3:2]] <= wd;
  end

  regfile_wb_sched dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
    .claim_valid(claim_valid), .claim_reg(claim_reg), .claim_ready(claim_ready),
    .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .stall(stall), .we(we), .wa(wa), .wd(wd), .sb_err(sb_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = '0;
    rst_n = 1'b0;
    a_valid = 1'b1; a_reg = 2'd0; a_data = 32'hA0A0_A0A0;
    b_valid = 1'b1; b_reg = 2'd1; b_data = 32'hB0B0_B0B0;
    claim_valid = 1'b0; claim_reg = 2'd0;
    rs1 = 2'd0; rs2 = 2'd0; rs1_used = 1'b0; rs2_used = 1'b0;

    // 1: reset state, contended grant goes to A first
    #2;
    chk("rst_a_ready", a_ready, 1);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_we", we, 0);
    chk("rst_wa", wa, 0);
    chk("rst_wd", wd, 0);
    chk("rst_sb_err", sb_err, 0);
    chk("rst_stall", stall, 0);
    chk("rst_claim_ready", claim_ready, 1);
    #5 rst_n = 1'b1;
    tick();
    chk("t1_we", we, 1);
    chk("t1_wa", wa, 32'h0);
    chk("t1_wd", wd, 32'hA0A0_A0A0);
    a_valid = 1'b0;
    #1;
    chk("t1_b_ready", b_ready, 1);
    tick();
    b_valid = 1'b0;
    chk("t1_b_wa", wa, 32'h4);
    chk("t1_b_wd", wd, 32'hB0B0_B0B0);
    chk("t1_mem0", mem[0], 32'hA0A0_A0A0);
    tick();
    chk("t1_unclaimed_err", sb_err, 1);
    chk("t1_we_idle", we, 0);
    #2 rst_n = 1'b0;
    #2;
    chk("rst2_sb_err", sb_err, 0);
    chk("rst2_wd", wd, 0);
    #2 rst_n = 1'b1;

    // 2: claim r1, r2; contended A/B for two cycles
    claim_valid = 1'b1; claim_reg = 2'd1;
    tick();
    claim_reg = 2'd2;
    tick();
    claim_valid = 1'b0;
    rs1 = 2'd1; rs1_used = 1'b1; rs2 = 2'd2; rs2_used = 1'b1;
    a_valid = 1'b1; a_reg = 2'd1; a_data = 32'h11;
    b_valid = 1'b1; b_reg = 2'd2; b_data = 32'h22;
    #1;
    chk("t2_stall_pre", stall, 1);
    chk("t2_a_ready", a_ready, 1);
    chk("t2_b_ready0", b_ready, 0);
    tick();
    chk("t2_a_we", we, 1);
    chk("t2_a_wa", wa, 32'h4);
    chk("t2_a_wd", wd, 32'h11);
    chk("t2_a_ready_rr", a_ready, 0);
    chk("t2_b_ready_rr", b_ready, 1);
    chk("t2_stall_mid", stall, 1);
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    chk("t2_b_we", we, 1);
    chk("t2_b_wa", wa, 32'h8);
    chk("t2_b_wd", wd, 32'h22);
    chk("t2_stall_r2", stall, 1);
    chk("t2_mem1", mem[1], 32'h11);
    tick();
    chk("t2_we_idle", we, 0);
    chk("t2_wa_hold", wa, 32'h8);
    chk("t2_wd_hold", wd, 32'h22);
    chk("t2_stall_clr", stall, 0);
    chk("t2_mem2", mem[2], 32'h22);
    chk("t2_sb_err", sb_err, 0);
    a_valid = 1'b1; b_valid = 1'b1;
    #1;
    chk("t2_rr_back_a", a_ready, 1);
    chk("t2_rr_back_b", b_ready, 0);
    a_valid = 1'b0; b_valid = 1'b0; rs1_used = 1'b0; rs2_used = 1'b0;

    // 3: claim r3, stall until load commit
    claim_valid = 1'b1; claim_reg = 2'd3;
    tick();
    claim_valid = 1'b0;
    rs1 = 2'd3; rs1_used = 1'b1;
    b_valid = 1'b1; b_reg = 2'd3; b_data = 32'hDEAD;
    #1;
    chk("t3_stall", stall, 1);
    chk("t3_b_ready", b_ready, 1);
    tick();
    b_valid = 1'b0;
    chk("t3_we", we, 1);
    chk("t3_wa", wa, 32'hC);
    chk("t3_stall_hold", stall, 1);
    tick();
    chk("t3_stall_drop", stall, 0);
    chk("t3_mem3", mem[3], 32'hDEAD);
    rs1_used = 1'b0;

    // 4: saturate r2, then claim alongside a commit to r2
    claim_valid = 1'b1; claim_reg = 2'd2;
    #1;
    chk("t4_claim_ok", claim_ready, 1);
    tick();
    tick();
    tick();
    chk("t4_claim_sat", claim_ready, 0);
    a_valid = 1'b1; a_reg = 2'd2; a_data = 32'h2222;
    tick();
    a_valid = 1'b0;
    chk("t4_commit_we", we, 1);
    chk("t4_commit_wa", wa, 32'h8);
    chk("t4_claim_commit", claim_ready, 1);
    tick();
    chk("t4_still_sat", claim_ready, 0);
    claim_valid = 1'b0;
    rs2 = 2'd2; rs2_used = 1'b1;
    #1;
    chk("t4_stall_r2", stall, 1);
    rs2_used = 1'b0;

    // 5: commit r0 with nothing pending
    a_valid = 1'b1; a_reg = 2'd0; a_data = 32'h5;
    tick();
    a_valid = 1'b0;
    chk("t5_err_before", sb_err, 0);
    chk("t5_wa", wa, 32'h0);
    tick();
    chk("t5_err_set", sb_err, 1);
    rs1 = 2'd0; rs1_used = 1'b1; claim_reg = 2'd0;
    #1;
    chk("t5_r0_no_stall", stall, 0);
    chk("t5_r0_claimable", claim_ready, 1);
    tick();
    chk("t5_err_sticky", sb_err, 1);

    // 6: reset the cycle after a grant
    rs1 = 2'd1; rs1_used = 1'b1;
    a_valid = 1'b1; a_reg = 2'd1; a_data = 32'h66;
    claim_valid = 1'b1; claim_reg = 2'd1;
    tick();
    a_valid = 1'b0; claim_valid = 1'b0;
    chk("t6_we_pre", we, 1);
    chk("t6_wd_pre", wd, 32'h66);
    chk("t6_stall_pre", stall, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_we_rst", we, 0);
    chk("t6_stall_rst", stall, 0);
    chk("t6_sb_err_rst", sb_err, 0);
    tick();
    chk("t6_no_write", mem[1], 32'h11);
    chk("t6_we_hold", we, 0);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
